// File: rtl/uart_rx_datapath.sv
// rtl/uart_rx_datapath.sv - UART receive datapath: bit shifter, parity accumulator and valid/ack holding register
module uart_rx_datapath #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 shift,
    input  logic                 clear,
    input  logic                 parity_reset,
    input  logic                 rx_ack,
    output logic                 done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int FRAME_BITS = DATA_BITS + PARITY_EN + 1;
    localparam int CW         = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BITS);
    localparam logic [CW-1:0] STOP_IDX  = CW'(FRAME_BITS - 1);
    localparam logic PEN  = (PARITY_EN != 0);
    localparam logic PODD = (PARITY_ODD != 0);

    logic [FRAME_BITS-1:0] sr;
    logic [CW-1:0]         bit_cnt;
    logic                  par;
    logic                  take_new;
    logic                  acked;

    assign take_new = ~rx_valid | rx_ack;
    assign acked    = rx_valid & rx_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            sr         <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
            done       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done <= (bit_cnt == FRAME_CNT);
            if (clear) begin
                bit_cnt <= '0;
                done    <= 1'b0;
                par     <= 1'b0;
                if (take_new) begin
                    rx_data    <= sr[DATA_BITS-1:0];
                    rx_valid   <= 1'b1;
                    parity_err <= PEN & (par ^ PODD);
                    frame_err  <= ~sr[FRAME_BITS-1];
                    if (acked) begin
                        overrun <= 1'b0;
                    end
                end else begin
                    overrun <= 1'b1;
                end
            end else begin
                if (acked) begin
                    rx_valid <= 1'b0;
                    overrun  <= 1'b0;
                end
                if (parity_reset) begin
                    bit_cnt <= '0;
                    par     <= 1'b0;
                    done    <= 1'b0;
                end else if (shift && (bit_cnt != FRAME_CNT)) begin
                    sr      <= {rx, sr[FRAME_BITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    // the stop bit is the last shift and stays out of the parity sum
                    if (bit_cnt != STOP_IDX) begin
                        par <= par ^ rx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_datapath.sv
// tb/tb_uart_rx_datapath.sv - table-driven self-checking bench for uart_rx_datapath
module tb_uart_rx_datapath;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx, shift, clear, parity_reset, rx_ack;
    logic       done, rx_valid, parity_err, frame_err, overrun;
    logic [7:0] rx_data;

    logic       rx_b, shift_b, clear_b, pr_b, ack_b;
    logic       done_b, valid_b, perr_b, ferr_b, ovr_b;
    logic [6:0] data_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    uart_rx_datapath dut (
        .clock(clock), .reset(reset), .rx(rx), .shift(shift), .clear(clear),
        .parity_reset(parity_reset), .rx_ack(rx_ack), .done(done), .rx_data(rx_data),
        .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
    );

    uart_rx_datapath #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0)) dut_b (
        .clock(clock), .reset(reset), .rx(rx_b), .shift(shift_b), .clear(clear_b),
        .parity_reset(pr_b), .rx_ack(ack_b), .done(done_b), .rx_data(data_b),
        .rx_valid(valid_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        logic       ack_clr;
        logic       ack_after;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_shift(input logic b);
        shift = 1'b1;
        rx    = b;
        tick();
        shift = 1'b0;
    endtask

    task automatic do_pr();
        parity_reset = 1'b1;
        tick();
        parity_reset = 1'b0;
    endtask

    task automatic do_clear(input logic ack);
        clear  = 1'b1;
        rx_ack = ack;
        tick();
        clear  = 1'b0;
        rx_ack = 1'b0;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
        do_pr();
        for (int i = 0; i < 8; i++) do_shift(d[i]);
        do_shift(pbit);
        do_shift(stop);
    endtask

    task automatic shift_b_bit(input logic b);
        shift_b = 1'b1;
        rx_b    = b;
        tick();
        shift_b = 1'b0;
    endtask

    task automatic clear_b_pulse();
        clear_b = 1'b1;
        tick();
        clear_b = 1'b0;
    endtask

    initial begin
        logic [7:0] d8;
        logic [6:0] d7;
        reset = 1'b1; rx = 1'b1; shift = 1'b0; clear = 1'b0; parity_reset = 1'b0; rx_ack = 1'b0;
        rx_b = 1'b1; shift_b = 1'b0; clear_b = 1'b0; pr_b = 1'b0; ack_b = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        check("reset_done", done, 0);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_perr", parity_err, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        check("reset_valid_b", valid_b, 0);

        //          data   par   stop  ackclr ackaft exp    pe    fe    ov
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].pbit, vecs[v].stop);
            tick();
            check($sformatf("v%0d_done", v), done, 1);
            do_clear(vecs[v].ack_clr);
            check($sformatf("v%0d_done_clr", v), done, 0);
            check($sformatf("v%0d_data", v), rx_data, vecs[v].exp_data);
            check($sformatf("v%0d_valid", v), rx_valid, 1);
            check($sformatf("v%0d_perr", v), parity_err, vecs[v].exp_pe);
            check($sformatf("v%0d_ferr", v), frame_err, vecs[v].exp_fe);
            check($sformatf("v%0d_ovr", v), overrun, vecs[v].exp_ov);
            if (vecs[v].ack_after) begin
                do_ack();
                check($sformatf("v%0d_ack_valid", v), rx_valid, 0);
                check($sformatf("v%0d_ack_ovr", v), overrun, 0);
                check($sformatf("v%0d_ack_data", v), rx_data, vecs[v].exp_data);
                check($sformatf("v%0d_ack_perr", v), parity_err, vecs[v].exp_pe);
            end
        end

        // partial frame cut by reset, then a full frame with latency and saturation checks
        do_pr();
        for (int i = 0; i < 4; i++) do_shift(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_done", done, 0);
        d8 = 8'h5A;
        do_pr();
        for (int i = 0; i < 8; i++) do_shift(d8[i]);
        do_shift(1'b0);
        check("lat_done_9", done, 0);
        do_shift(1'b1);
        check("lat_done_10_same_edge", done, 0);
        do_shift(1'b0);
        check("lat_done_next", done, 1);
        do_shift(1'b0);
        do_clear(1'b0);
        check("rst_data", rx_data, 8'h5A);
        check("rst_valid", rx_valid, 1);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);

        // 7 data bits, no parity: frame is 8 bits long
        d7 = 7'h41;
        pr_b = 1'b1; tick(); pr_b = 1'b0;
        for (int i = 0; i < 7; i++) shift_b_bit(d7[i]);
        tick();
        check("b_done_7", done_b, 0);
        shift_b_bit(1'b1);
        tick();
        check("b_done_8", done_b, 1);
        clear_b_pulse();
        check("b_data", data_b, 7'h41);
        check("b_valid", valid_b, 1);
        check("b_perr", perr_b, 0);
        check("b_ferr", ferr_b, 0);
        ack_b = 1'b1; tick(); ack_b = 1'b0;
        d7 = 7'h7F;
        pr_b = 1'b1; tick(); pr_b = 1'b0;
        for (int i = 0; i < 7; i++) shift_b_bit(d7[i]);
        shift_b_bit(1'b1);
        tick();
        clear_b_pulse();
        check("b2_data", data_b, 7'h7F);
        check("b2_perr", perr_b, 0);
        check("b2_ovr", ovr_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_datapath.md
# uart_rx_datapath

Receive datapath for the serial UART receiver: it samples the `rx` line on every `shift` strobe issued by the receive controller and counts bits. It raises `done` to the controller when a full frame has been captured. On `clear`, it checks the frame's parity and stop bit and presents the data word through a valid/ack holding register. It sits directly downstream of the receive controller and upstream of the consumer logic (display, FIFO or command decoder).

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5..9, sent LSB first.
- `PARITY_EN`, 1: 1 = a parity bit follows the data, 0 = no parity bit.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line, already synchronised to `clock`.
- `shift`  in  1  one-cycle strobe from the controller: sample `rx`.
- `clear`  in  1  one-cycle strobe from the controller: frame complete, evaluate and restart.
- `parity_reset`  in  1  one-cycle strobe at start-bit detect: clear the parity accumulator and bit counter.
- `rx_ack`  in  1  consumer has taken `rx_data`.
- `done`  out  1  registered; high while the frame bit count is reached.
- `rx_data`  out  DATA_BITS  last accepted data word.
- `rx_valid`  out  1  `rx_data` holds an unacknowledged word.
- `parity_err`  out  1  parity mismatch on the word in `rx_data`.
- `frame_err`  out  1  stop bit sampled as 0 on the word in `rx_data`.
- `overrun`  out  1  sticky: a frame completed while `rx_valid` was high.

## Operation
- `FRAME_BITS` = `DATA_BITS` + `PARITY_EN` + 1 (stop bit). The start bit is consumed by the controller and is never shifted in.
- Shift register `sr`, `FRAME_BITS` wide:
  - On `shift`, `sr` <= {`rx`, `sr`[FRAME_BITS-1:1]`}`.
  - After `FRAME_BITS` shifts: `sr`[MSB] = stop bit, `sr`[MSB-1] = parity bit (if enabled), `sr`[DATA_BITS-1:0] = data.
- Bit counter `bit_cnt`, $clog2(`FRAME_BITS`+1) bits:
  - Increments on `shift`.
  - Saturates at `FRAME_BITS`; further `shift` strobes are ignored for both `sr` and `bit_cnt`.
- `done` <= (`bit_cnt` == `FRAME_BITS`), registered. It stays high until `clear`, `parity_reset` or `reset`.
- Parity accumulator `par`: XOR of every sampled data bit and parity bit; the stop bit is excluded. Zeroed by `parity_reset`.
- On `clear`, with evaluation taken from the current `sr` and `par`:
  - If `rx_valid`=0 or `rx_ack`=1:
    - `rx_data` <= data field.
    - `rx_valid` <= 1.
    - `parity_err` <= `PARITY_EN` & (`par` != `PARITY_ODD`).
    - `frame_err` <= ~stop bit.
  - Else (`rx_valid`=1 and `rx_ack`=0): the held word and its error flags are kept unchanged, the new frame is discarded, and `overrun` <= 1.
  - In both cases: `bit_cnt` <= 0, `done` <= 0, `par` <= 0.
- `rx_ack` while `rx_valid`=1 and no `clear` in the same cycle:
  - `rx_valid` <= 0 and `overrun` <= 0.
  - `rx_data`, `parity_err` and `frame_err` hold their values.
- `rx_ack` while `rx_valid`=0: ignored.

## Timing
- Reset values: `done`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `rx_data`=0; internally `sr`=0, `bit_cnt`=0, `par`=0.
- Reset mid-frame discards the partial frame. Reset has priority over every other input.
- `done` rises on the edge after the clock edge that performs the `FRAME_BITS`-th shift (1-cycle latency).
- `rx_valid` and error flags update on the `clear` edge, so they are visible the cycle after `clear`.
- Priority when strobes coincide: `reset` > `clear` > `parity_reset` > `shift`. A lower-priority strobe in the same cycle is ignored.
- `clear` together with `rx_ack` while `rx_valid`=1: the new word loads, `rx_valid` stays 1, and `overrun` is not set.
- A new frame's `parity_reset`/`shift` strobes are accepted while `rx_valid`=1; only `clear` consults the handshake.

## Test plan
- Defaults, frame data 0xA5, parity 0, stop 1: after 10 shifts `done`=1; after `clear`, `rx_data`=0xA5, `rx_valid`=1, `parity_err`=0, `frame_err`=0.
- Same frame with parity bit 1 -> `parity_err`=1, `rx_data`=0xA5. Same frame with stop 0 -> `frame_err`=1.
- Overrun: frame 0xA5 with no ack, then frame 0x3C -> `rx_data` stays 0xA5, `overrun`=1. `rx_ack` -> `rx_valid`=0 and `overrun`=0.
- Reset after 4 shifts, then a full frame 0x5A -> `rx_data`=0x5A; no residue from the partial frame.
- `clear` coincident with `rx_ack` on held word 0xA5, new frame 0x3C -> `rx_data`=0x3C, `rx_valid`=1, `overrun`=0.
- `PARITY_EN`=0, `DATA_BITS`=7, data 0x41 -> `done` after 8 shifts; `rx_data`=0x41; `parity_err` stays 0 even with arbitrary line data.
